// File: rtl/ftdi_fifo_emulator.sv
// ftdi_fifo_emulator: FT245-style FIFO emulator with 14-bit sample encoder/decoder.
// Define FIFO_EMU_LOOPBACK_EN to route decoded samples back into the encoder.
module ftdi_fifo_emulator #(
    parameter int RXF_PRECHARGE = 2,
    parameter int TXE_PRECHARGE = 2,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    inout  wire  [7:0]  data_io,
    output logic        nRXF_o,
    output logic        nTXE_o,
    input  logic        nRD_i,
    input  logic        nWR_i,
    input  logic [13:0] sample_i,
    input  logic        sample_valid_i,
    output logic        sample_ready_o,
    output logic [13:0] sample_o,
    output logic        sample_valid_o,
    output logic        frame_err_o,
    output logic        proto_err_o,
    output logic [15:0] err_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {WAIT_HI, WAIT_LO} dec_state_t;

    dec_state_t  state;
    logic        rd_q, wr_q, rd_busy, rd_udr, wr_busy;
    logic [7:0]  wr_byte;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, used;
    logic [15:0] rxf_cnt, txe_cnt;
    logic [6:0]  hi;
    logic [16:0] err_sum;
    logic        room, push, pop, enc_valid, drop;
    logic [13:0] enc_data;
    logic        rd_fall, rd_rise, wr_fall, wr_rise;
    logic        udr, coll, ovr, wr_start, commit;

    assign used    = wr_ptr - rd_ptr;
    assign room    = used <= (AW+1)'(FIFO_DEPTH - 2);
    assign rd_fall = rd_q & ~nRD_i;
    assign rd_rise = ~rd_q & nRD_i;
    assign wr_fall = wr_q & ~nWR_i;
    assign wr_rise = ~wr_q & nWR_i;

    assign nRXF_o = ~((used != '0) && !rd_busy && (rxf_cnt == '0));
    // The precharge counter alone decides overrun; nWR_i low would otherwise mask every write.
    assign nTXE_o = reset_i | (txe_cnt != '0) | ~nWR_i;

    assign udr      = rd_fall & nRXF_o;
    assign pop      = rd_rise & rd_busy & ~rd_udr;
    assign coll     = ~nRD_i & (wr_fall | (wr_rise & wr_busy));
    assign ovr      = wr_fall & nRD_i & (txe_cnt != '0);
    assign wr_start = wr_fall & nRD_i & (txe_cnt == '0);
    assign commit   = wr_rise & wr_busy & nRD_i;

`ifdef FIFO_EMU_LOOPBACK_EN
    assign enc_valid      = sample_valid_o;
    assign enc_data       = sample_o;
    assign sample_ready_o = 1'b0;
    assign drop           = sample_valid_o & ~room;
`else
    assign enc_valid      = sample_valid_i;
    assign enc_data       = sample_i;
    assign sample_ready_o = room;
    assign drop           = 1'b0;
`endif

    assign push    = enc_valid & room;
    assign err_sum = {1'b0, err_cnt_o} + 17'(frame_err_o) + 17'(proto_err_o);
    assign data_io = rd_busy ? (rd_udr ? 8'h00 : mem[rd_ptr[AW-1:0]]) : 8'hzz;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]]          <= {1'b1, enc_data[13:7]};
            mem[wr_ptr[AW-1:0] + AW'(1)] <= {1'b0, enc_data[6:0]};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
            rd_busy        <= 1'b0;
            rd_udr         <= 1'b0;
            wr_busy        <= 1'b0;
            wr_byte        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            rxf_cnt        <= '0;
            txe_cnt        <= '0;
            state          <= WAIT_HI;
            hi             <= '0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            frame_err_o    <= 1'b0;
            proto_err_o    <= 1'b0;
            err_cnt_o      <= '0;
        end else begin
            rd_q           <= nRD_i;
            wr_q           <= nWR_i;
            sample_valid_o <= 1'b0;
            frame_err_o    <= 1'b0;
            proto_err_o    <= udr | coll | ovr | drop;
            err_cnt_o      <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            rxf_cnt        <= (rxf_cnt != '0) ? rxf_cnt - 16'd1 : '0;
            txe_cnt        <= (txe_cnt != '0) ? txe_cnt - 16'd1 : '0;
            if (rd_fall) begin
                rd_busy <= 1'b1;
                rd_udr  <= udr;
            end else if (rd_rise && rd_busy) begin
                rd_busy <= 1'b0;
                rd_udr  <= 1'b0;
                rxf_cnt <= 16'(RXF_PRECHARGE);
            end
            if (!nWR_i)
                wr_byte <= data_io;
            if (wr_start)
                wr_busy <= 1'b1;
            else if (wr_rise)
                wr_busy <= 1'b0;
            if (commit) begin
                txe_cnt <= 16'(TXE_PRECHARGE);
                if (state == WAIT_HI) begin
                    if (wr_byte[7]) begin
                        hi    <= wr_byte[6:0];
                        state <= WAIT_LO;
                    end else
                        frame_err_o <= 1'b1;
                end else if (wr_byte[7]) begin
                    hi          <= wr_byte[6:0];
                    frame_err_o <= 1'b1;
                end else begin
                    sample_o       <= {hi, wr_byte[6:0]};
                    sample_valid_o <= 1'b1;
                    state          <= WAIT_HI;
                end
            end
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(2);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: tb/tb_ftdi_fifo_emulator.sv
// tb_ftdi_fifo_emulator: directed bench for ftdi_fifo_emulator with hand-computed expectations.
module tb_ftdi_fifo_emulator;
    logic        clk_i = 1'b0, reset_i = 1'b1, nRD_i = 1'b1, nWR_i = 1'b1;
    logic        sample_valid_i = 1'b0, tb_oe = 1'b0;
    logic [7:0]  tb_drv = 8'h00;
    logic [13:0] sample_i = '0;
    wire  [7:0]  data_io;
    logic        nRXF_o, nTXE_o, sample_ready_o, sample_valid_o, frame_err_o, proto_err_o;
    logic [13:0] sample_o;
    logic [15:0] err_cnt_o;
    int          n_chk = 0, n_pass = 0, sv_n = 0, fe_n = 0, pe_n = 0;
    int          sv0, fe0, pe0;

    ftdi_fifo_emulator dut (
        .clk_i(clk_i), .reset_i(reset_i), .data_io(data_io), .nRXF_o(nRXF_o), .nTXE_o(nTXE_o),
        .nRD_i(nRD_i), .nWR_i(nWR_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .sample_ready_o(sample_ready_o), .sample_o(sample_o), .sample_valid_o(sample_valid_o),
        .frame_err_o(frame_err_o), .proto_err_o(proto_err_o), .err_cnt_o(err_cnt_o)
    );

    assign data_io = tb_oe ? tb_drv : 8'hzz;

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (sample_valid_o) sv_n++;
        if (frame_err_o) fe_n++;
        if (proto_err_o) pe_n++;
    end

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task snap;
        sv0 = sv_n; fe0 = fe_n; pe0 = pe_n;
    endtask

    task do_reset;
        reset_i = 1'b1; nRD_i = 1'b1; nWR_i = 1'b1; sample_valid_i = 1'b0; tb_oe = 1'b0;
        tick(2);
        reset_i = 1'b0;
        tick(2);
    endtask

    task push(input logic [13:0] s);
        sample_i = s; sample_valid_i = 1'b1;
        tick(1);
        sample_valid_i = 1'b0;
    endtask

    task rd(output logic [7:0] b);
        for (int i = 0; i < 50 && nRXF_o; i++) tick(1);
        check("rxf_ready", nRXF_o, 0);
        nRD_i = 1'b0;
        tick(2);
        b = data_io;
        nRD_i = 1'b1;
        tick(1);
    endtask

    task wr(input logic [7:0] b);
        for (int i = 0; i < 50 && nTXE_o; i++) tick(1);
        check("txe_ready", nTXE_o, 0);
        tb_drv = b; tb_oe = 1'b1; nWR_i = 1'b0;
        tick(1);
        nWR_i = 1'b1;
        tick(1);
        tb_oe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  b;
        logic [13:0] samp [4] = '{14'h0000, 14'h3FFF, 14'h1234, 14'h2ABC};
        logic [7:0]  exp_b [8] = '{8'h80, 8'h00, 8'hFF, 8'h7F, 8'hA4, 8'h34, 8'hD5, 8'h3C};
        tick(3);
        check("rst_nrxf", nRXF_o, 1);
        check("rst_ntxe", nTXE_o, 1);
        check("rst_sample", sample_o, 0);
        check("rst_valid", sample_valid_o, 0);
        check("rst_proto", proto_err_o, 0);
        check("rst_errcnt", err_cnt_o, 0);
        reset_i = 1'b0;
        tick(2);
        check("idle_ntxe", nTXE_o, 0);
        check("idle_nrxf", nRXF_o, 1);

        do_reset;
        snap;
        wr(8'h81);
        wr(8'h05);
        tick(3);
        check("dec_sample", sample_o, 14'h0085);
        check("dec_valid_n", sv_n - sv0, 1);
        check("dec_errcnt", err_cnt_o, 0);

        do_reset;
        snap;
        wr(8'h05);
        wr(8'h81);
        wr(8'h82);
        wr(8'h03);
        tick(3);
        check("frm_fe_n", fe_n - fe0, 2);
        check("frm_sample", sample_o, 14'h0103);
        check("frm_valid_n", sv_n - sv0, 1);
        check("frm_errcnt", err_cnt_o, 2);

        do_reset;
        snap;
        reset_i = 1'b1; tb_drv = 8'h05; tb_oe = 1'b1; nWR_i = 1'b0;
        tick(2);
        reset_i = 1'b0;
        tick(2);
        check("rstwr_ntxe", nTXE_o, 1);
        nWR_i = 1'b1;
        tick(3);
        tb_oe = 1'b0;
        check("rstwr_fe_n", fe_n - fe0, 0);
        check("rstwr_errcnt", err_cnt_o, 0);

`ifdef FIFO_EMU_LOOPBACK_EN
        do_reset;
        check("lb_ready", sample_ready_o, 0);
        wr(8'hFF);
        wr(8'h7F);
        rd(b);
        check("lb_rd0", b, 8'hFF);
        rd(b);
        check("lb_rd1", b, 8'h7F);
`else
        do_reset;
        check("enc_ready", sample_ready_o, 1);
        push(14'h2ABC);
        check("enc_nrxf", nRXF_o, 0);
        rd(b);
        check("enc_rd0", b, 8'hD5);
        check("pre0_c0", nRXF_o, 1);
        tick(1);
        check("pre0_c1", nRXF_o, 1);
        tick(1);
        check("pre0_c2", nRXF_o, 0);
        rd(b);
        check("enc_rd1", b, 8'h3C);
        check("pre1_c0", nRXF_o, 1);
        tick(1);
        check("pre1_c1", nRXF_o, 1);
        tick(1);
        check("drain_nrxf", nRXF_o, 1);

        do_reset;
        sample_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_i = samp[i];
            check("full_ready_pre", sample_ready_o, 1);
            tick(1);
        end
        sample_valid_i = 1'b0;
        check("full_ready", sample_ready_o, 0);
        rd(b);
        check("full_rd0", b, exp_b[0]);
        check("full_ready7", sample_ready_o, 0);
        rd(b);
        check("full_rd1", b, exp_b[1]);
        check("full_ready6", sample_ready_o, 1);
        for (int i = 2; i < 8; i++) begin
            rd(b);
            check("full_rdn", b, exp_b[i]);
        end
        tick(3);
        check("empty_nrxf", nRXF_o, 1);
        snap;
        nRD_i = 1'b0;
        tick(2);
        check("udr_data", data_io, 8'h00);
        nRD_i = 1'b1;
        tick(3);
        check("udr_pe_n", pe_n - pe0, 1);

        do_reset;
        push(14'h0001);
        snap;
        nRD_i = 1'b0;
        tick(2);
        nWR_i = 1'b0;
        tick(1);
        nWR_i = 1'b1;
        tick(1);
        check("coll_rd", data_io, 8'h80);
        nRD_i = 1'b1;
        tick(3);
        check("coll_pe_n", pe_n - pe0, 1);
        rd(b);
        check("coll_rd2", b, 8'h01);
        wr(8'h81);
        tb_drv = 8'h05; tb_oe = 1'b1; nWR_i = 1'b0;
        tick(1);
        nWR_i = 1'b1;
        tick(1);
        tb_oe = 1'b0;
        tick(3);
        check("ovr_pe_n", pe_n - pe0, 2);
        check("ovr_valid_n", sv_n - sv0, 0);
        check("ovr_errcnt", err_cnt_o, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
